// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: word width, engine states and
// SPI mode encodings ({CPOL,CPHA}).
package spi_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_engine_if.sv
// Parallel byte side of the SPI responder: TX/RX valid-ready handshakes and
// the overrun/underrun status pulses exchanged with the local register block.
interface spi_slave_engine_if #(parameter int DATA = spi_pkg::DATA_W) ();

  logic [DATA-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [DATA-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ack;
  logic            overrun;
  logic            underrun;

  modport slave (
    input  tx_data, tx_valid, rx_ack,
    output tx_ready, rx_data, rx_valid, overrun, underrun
  );

  modport master (
    output tx_data, tx_valid, rx_ack,
    input  tx_ready, rx_data, rx_valid, overrun, underrun
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus edge detection of the
// synchronised level against its registered copy.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic PRESETn,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge CLK or negedge PRESETn) begin
    if (!PRESETn) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_engine.sv
// SPI responder shift engine: one byte in and one byte out per word, framed
// by SS_n, with a one-deep TX holding register and an RX output register.
module spi_slave_engine
  import spi_pkg::*;
#(
  parameter int              DATA  = DATA_W,
  parameter logic [DATA-1:0] DUMMY = 8'hFF
) (
  input  logic CLK,
  input  logic PRESETn,
  input  logic SPE,
  input  logic CPOL,
  input  logic CPHA,
  input  logic SCK,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic MISO_OE,
  spi_slave_engine_if.slave bus
);

  localparam int CW = $clog2(DATA);

  state_t          state, state_next;
  logic [DATA-1:0] hold;
  logic [DATA-1:0] tx_shift;
  logic [DATA-1:0] rx_shift;
  logic [CW-1:0]   bitcnt;

  logic sck_sync, sck_rise, sck_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic active, complete, load_msb;
  logic unused_sync;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck (
    .CLK(CLK), .PRESETn(PRESETn), .pin(SCK),
    .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_ss (
    .CLK(CLK), .PRESETn(PRESETn), .pin(SS_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
    .CLK(CLK), .PRESETn(PRESETn), .pin(MOSI),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sck_sync, ss_sync, mosi_rise, mosi_fall};

  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  assign active   = SPE && (state == SHIFT) && !ss_rise;
  assign complete = active && sample_edge && (bitcnt == CW'(DATA - 1));

  always_ff @(posedge CLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!SPE) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (ss_fall) state_next = LOAD;
        LOAD:    state_next = ss_rise ? IDLE : SHIFT;
        SHIFT: begin
          if (ss_rise)       state_next = IDLE;
          else if (complete) state_next = LOAD;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A shift edge only advances MISO once a bit of the current word has been
  // sampled: this skips the CPHA=1 first leading edge and, in back-to-back
  // CPHA=0 words, the trailing edge that would otherwise drop the fresh MSB.
  always_ff @(posedge CLK or negedge PRESETn) begin
    if (!PRESETn) begin
      hold         <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bitcnt       <= '0;
      bus.tx_ready <= 1'b1;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.overrun  <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      bus.overrun  <= 1'b0;
      bus.underrun <= 1'b0;

      if (bus.tx_valid && bus.tx_ready) begin
        hold         <= bus.tx_data;
        bus.tx_ready <= 1'b0;
      end

      if (SPE && state == LOAD) begin
        bitcnt <= '0;
        if (!bus.tx_ready) begin
          tx_shift     <= hold;
          bus.tx_ready <= 1'b1;
        end else begin
          tx_shift     <= DUMMY;
          bus.underrun <= 1'b1;
        end
      end

      if (active) begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[DATA-2:0], mosi_sync};
          bitcnt   <= bitcnt + 1'b1;
        end
        if (shift_edge && bitcnt != '0)
          tx_shift <= {tx_shift[DATA-2:0], 1'b0};
      end

      if (complete) begin
        bus.rx_data  <= {rx_shift[DATA-2:0], mosi_sync};
        bus.rx_valid <= 1'b1;
        bus.overrun  <= bus.rx_valid && !bus.rx_ack;
      end else if (bus.rx_ack) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

  // During LOAD the MSB is shown straight from its source so CPHA=0 masters
  // see valid data before the first leading edge.
  assign load_msb = bus.tx_ready ? DUMMY[DATA-1] : hold[DATA-1];
  assign MISO_OE  = SPE && (state != IDLE);
  assign MISO     = MISO_OE && ((state == LOAD) ? load_msb : tx_shift[DATA-1]);

endmodule

// File: tb/tb_spi_slave_engine.sv
// Directed bench for spi_slave_engine: the bench acts as SPI master and as the
// local register block, checking each step against hand-computed values.
module tb_spi_slave_engine;
  import spi_pkg::*;

  localparam int H = 8;

  logic CLK = 1'b0;
  logic PRESETn = 1'b0;
  logic SPE = 1'b0;
  logic CPOL = 1'b0;
  logic CPHA = 1'b0;
  logic SCK = 1'b0;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO, MISO_OE;

  int checks = 0;
  int failures = 0;
  int ov_cnt = 0;
  int un_cnt = 0;
  int rxv_rise = 0;
  logic rxv_d = 1'b0;

  spi_slave_engine_if #(.DATA(8)) bus ();

  spi_slave_engine #(.DATA(8), .DUMMY(8'hFF)) dut (
    .CLK(CLK), .PRESETn(PRESETn), .SPE(SPE), .CPOL(CPOL), .CPHA(CPHA),
    .SCK(SCK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Status pulses last a single CLK, so they are tallied as they happen.
  always @(negedge CLK) begin
    if (bus.overrun)  ov_cnt++;
    if (bus.underrun) un_cnt++;
    if (bus.rx_valid && !rxv_d) rxv_rise++;
    rxv_d = bus.rx_valid;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_mode(input logic [1:0] m);
    CPOL = m[1];
    CPHA = m[0];
    SCK  = m[1];
    wait_clks(4);
  endtask

  task automatic push_tx(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    wait_clks(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic ack_rx();
    bus.rx_ack = 1'b1;
    wait_clks(1);
    bus.rx_ack = 1'b0;
    wait_clks(1);
  endtask

  task automatic frame_start();
    SS_n = 1'b0;
    wait_clks(4);
  endtask

  task automatic frame_end();
    wait_clks(H);
    SS_n = 1'b1;
    wait_clks(6);
  endtask

  // Master side of nbits of one word; with ack_last the consumer acknowledges
  // in exactly the CLK where the final sample completes the word (mode 0).
  task automatic apply_stimulus(input logic [7:0] mo, input int nbits, input bit ack_last,
                                output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!CPHA) begin
        MOSI = mo[i];
        wait_clks(H);
        mi = {mi[6:0], MISO};
        SCK = ~CPOL;
        if (ack_last && i == 0) begin
          wait_clks(2);
          bus.rx_ack = 1'b1;
          wait_clks(1);
          bus.rx_ack = 1'b0;
          wait_clks(H - 3);
        end else begin
          wait_clks(H);
        end
        SCK = CPOL;
      end else begin
        wait_clks(H);
        SCK  = ~CPOL;
        MOSI = mo[i];
        wait_clks(H);
        mi = {mi[6:0], MISO};
        SCK = CPOL;
      end
    end
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int un0, ov0, rv0;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ack   = 1'b0;

    wait_clks(3);
    check_output("rst_miso",     32'(MISO), 32'h0);
    check_output("rst_miso_oe",  32'(MISO_OE), 32'h0);
    check_output("rst_tx_ready", 32'(bus.tx_ready), 32'h1);
    check_output("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check_output("rst_rx_data",  32'(bus.rx_data), 32'h0);
    check_output("rst_overrun",  32'(bus.overrun), 32'h0);
    check_output("rst_underrun", 32'(bus.underrun), 32'h0);

    PRESETn = 1'b1;
    SPE = 1'b1;
    set_mode(MODE0);

    // Mode 0 single word; the LOAD after completion finds the holding empty.
    push_tx(8'hA5);
    check_output("m0_tx_ready_full", 32'(bus.tx_ready), 32'h0);
    un0 = un_cnt; ov0 = ov_cnt; rv0 = rxv_rise;
    frame_start();
    apply_stimulus(8'h3C, 8, 1'b0, mi);
    frame_end();
    check_output("m0_miso",      32'(mi), 32'hA5);
    check_output("m0_rx_data",   32'(bus.rx_data), 32'h3C);
    check_output("m0_rx_valid",  32'(bus.rx_valid), 32'h1);
    check_output("m0_rxv_count", 32'(rxv_rise - rv0), 32'h1);
    check_output("m0_tx_ready",  32'(bus.tx_ready), 32'h1);
    check_output("m0_underrun",  32'(un_cnt - un0), 32'h1);
    check_output("m0_overrun",   32'(ov_cnt - ov0), 32'h0);
    check_output("m0_miso_oe",   32'(MISO_OE), 32'h0);
    ack_rx();
    check_output("m0_ack", 32'(bus.rx_valid), 32'h0);

    for (int m = 1; m < 4; m++) begin
      logic [1:0] mode;
      mode = 2'(m);
      set_mode(mode);
      push_tx(8'h5A);
      frame_start();
      apply_stimulus(8'hC3, 8, 1'b0, mi);
      frame_end();
      check_output($sformatf("mode%0d_miso", m),    32'(mi), 32'h5A);
      check_output($sformatf("mode%0d_rx_data", m), 32'(bus.rx_data), 32'hC3);
      ack_rx();
    end

    // Two words in one frame, no ack and nothing queued for the second.
    set_mode(MODE0);
    push_tx(8'h81);
    un0 = un_cnt; ov0 = ov_cnt;
    frame_start();
    apply_stimulus(8'h12, 8, 1'b0, mi);
    apply_stimulus(8'h34, 8, 1'b0, mi2);
    frame_end();
    check_output("b2b_miso1",    32'(mi), 32'h81);
    check_output("b2b_miso2",    32'(mi2), 32'hFF);
    check_output("b2b_underrun", 32'(un_cnt - un0), 32'h2);
    check_output("b2b_overrun",  32'(ov_cnt - ov0), 32'h1);
    check_output("b2b_rx_data",  32'(bus.rx_data), 32'h34);
    check_output("b2b_rx_valid", 32'(bus.rx_valid), 32'h1);
    ack_rx();

    // Abort after four bits.
    push_tx(8'h96);
    rv0 = rxv_rise;
    frame_start();
    apply_stimulus(8'hB4, 4, 1'b0, mi);
    SS_n = 1'b1;
    wait_clks(3);
    check_output("abort_miso_oe", 32'(MISO_OE), 32'h0);
    wait_clks(6);
    check_output("abort_rx_valid", 32'(bus.rx_valid), 32'h0);
    check_output("abort_rxv_count", 32'(rxv_rise - rv0), 32'h0);
    check_output("abort_rx_data", 32'(bus.rx_data), 32'h34);
    check_output("abort_tx_ready", 32'(bus.tx_ready), 32'h1);
    push_tx(8'h69);
    frame_start();
    apply_stimulus(8'hF0, 8, 1'b0, mi);
    frame_end();
    check_output("after_abort_miso",    32'(mi), 32'h69);
    check_output("after_abort_rx_data", 32'(bus.rx_data), 32'hF0);
    ack_rx();

    // Reset in the middle of a word.
    push_tx(8'h77);
    frame_start();
    apply_stimulus(8'hAA, 5, 1'b0, mi);
    PRESETn = 1'b0;
    #1;
    check_output("mrst_miso_oe",  32'(MISO_OE), 32'h0);
    check_output("mrst_miso",     32'(MISO), 32'h0);
    check_output("mrst_rx_data",  32'(bus.rx_data), 32'h0);
    check_output("mrst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check_output("mrst_tx_ready", 32'(bus.tx_ready), 32'h1);
    wait_clks(1);
    SS_n = 1'b1;
    SCK  = CPOL;
    wait_clks(3);
    PRESETn = 1'b1;
    wait_clks(3);
    push_tx(8'h3E);
    frame_start();
    apply_stimulus(8'hE7, 8, 1'b0, mi);
    frame_end();
    check_output("after_rst_miso",    32'(mi), 32'h3E);
    check_output("after_rst_rx_data", 32'(bus.rx_data), 32'hE7);
    ack_rx();

    // Block disabled mid-frame.
    push_tx(8'h55);
    rv0 = rxv_rise;
    frame_start();
    apply_stimulus(8'h0F, 3, 1'b0, mi);
    SPE = 1'b0;
    wait_clks(1);
    check_output("spe_off_miso_oe", 32'(MISO_OE), 32'h0);
    apply_stimulus(8'h0F, 5, 1'b0, mi);
    frame_end();
    check_output("spe_off_rx_valid", 32'(bus.rx_valid), 32'h0);
    check_output("spe_off_rxv_count", 32'(rxv_rise - rv0), 32'h0);
    SPE = 1'b1;
    wait_clks(4);

    // Acknowledge landing on the same CLK as the next completion.
    push_tx(8'h11);
    frame_start();
    apply_stimulus(8'h22, 8, 1'b0, mi);
    frame_end();
    check_output("coin_pre_valid", 32'(bus.rx_valid), 32'h1);
    push_tx(8'h33);
    ov0 = ov_cnt;
    frame_start();
    apply_stimulus(8'h44, 8, 1'b1, mi);
    frame_end();
    check_output("coin_miso",     32'(mi), 32'h33);
    check_output("coin_rx_valid", 32'(bus.rx_valid), 32'h1);
    check_output("coin_rx_data",  32'(bus.rx_data), 32'h44);
    check_output("coin_overrun",  32'(ov_cnt - ov0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_engine.md
Name: spi_slave_engine

Overview:
SPI responder (slave-side) shift engine. It is the far end of the link driven by our SPI master controller. It synchronises the external SCK, SS_n and MOSI pins into the CLK domain, and shifts one byte in and one byte out per SS_n-framed transfer. It exchanges parallel bytes with the local register block through valid/ready handshakes, and flags overrun and underrun.

Parameters:
DATA, 8, transfer word width in bits
DUMMY, 8'hFF, byte shifted out when no TX byte is queued (width DATA)

Ports:
CLK  in  1  system clock
PRESETn  in  1  asynchronous active-low reset
SPE  in  1  block enable; 0 forces IDLE and tri-states MISO
CPOL  in  1  SCK idle level
CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge
SCK  in  1  serial clock from master (asynchronous)
SS_n  in  1  slave select, active-low (asynchronous)
MOSI  in  1  serial data in (asynchronous)
MISO  out  1  serial data out
MISO_OE  out  1  MISO pad output enable
tx_data  in  DATA  next byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding register empty
rx_data  out  DATA  last received byte
rx_valid  out  1  rx_data holds an unconsumed byte
rx_ack  in  1  consumer acknowledges rx_data
overrun  out  1  one-CLK pulse: byte received while rx_valid=1
underrun  out  1  one-CLK pulse: DUMMY loaded because TX holding register was empty

Behaviour:
- Reset: PRESETn is asynchronous, active-low; CLK is the clock. All outputs are 0 except tx_ready=1. The state is IDLE, shift registers are 0 and the bit counter is 0.
- Synchronisers: two-flop synchronisers on SCK, SS_n and MOSI (SS_n resets to 1, SCK resets to 0). Edges are detected from the synchronised SCK against its registered copy.
- SCK frequency must be ≤ CLK/8. Pin-to-internal latency is 2 CLK.
- Leading edge = SCK leaving the CPOL level. Trailing edge = SCK returning to the CPOL level.
- TX holding register:
  - tx_valid && tx_ready writes it and clears tx_ready.
  - tx_ready is set again when the byte is moved into the shift register.
- States:
  - IDLE: MISO_OE=0. Entered on SPE=0 from any state, with no other effect.
    - Synced SS_n falling with SPE=1 -> LOAD.
  - LOAD (1 CLK): tx_shift ← holding register if full, else DUMMY with an underrun pulse.
    - MISO = tx_shift MSB immediately; this is required for CPHA=0.
    - bitcnt ← 0; -> SHIFT.
  - SHIFT: MISO_OE=1. Data is MSB first.
    - Sample edge: rx_shift ← {rx_shift[DATA-2:0], MOSI_sync}; bitcnt++.
    - Shift edge: MISO advances to the next bit.
    - CPHA=1 only: the first leading edge of a frame does not shift; it presents the MSB already loaded.
    - Sample edge with bitcnt==DATA-1: rx_data ← completed byte and rx_valid=1 on the next CLK. If rx_valid was already 1, pulse overrun and overwrite rx_data. Then -> LOAD for back-to-back bytes in the same frame.
    - Synced SS_n rising at any point -> IDLE. The partial byte is discarded, with no rx_valid, no overrun, and rx_data unchanged. A byte already moved into tx_shift is consumed and lost.
- rx_valid is cleared by rx_ack. If rx_ack and a new completion occur in the same CLK, the new byte wins: rx_valid stays 1 and no overrun pulse is generated.
- tx write and LOAD in the same CLK: LOAD takes the previous holding contents (or DUMMY). The new write is accepted into the now-empty holding register only if tx_ready was 1 in that cycle.
- MISO_OE = SPE && state != IDLE. MISO = 0 whenever MISO_OE=0.
- Mode change (CPOL/CPHA) while SS_n is low is undefined. The bench must not do it.

Decomposition:
- Shared package spi_pkg: state encoding (IDLE/LOAD/SHIFT), DATA default, and mode constants (MODE0..MODE3 as {CPOL,CPHA}).
- One sub-module: spi_sync_edge. It is a two-flop synchroniser plus registered edge detect, instanced for SCK, SS_n and MOSI, and outputs sync, rise and fall.

Test Plan:
- Mode 0: tx byte 0xA5 queued, master shifts 0x3C -> MISO carries 1010_0101; rx_data=0x3C with one rx_valid; tx_ready returns 1 after LOAD.
- Modes 1/2/3: same exchange with 0x5A/0xC3 -> each mode yields correct MISO bits and rx_data=0xC3.
- Back-to-back: two bytes in one SS_n frame, no rx_ack between them, TX queue empty for the second -> second byte shifts 0xFF with an underrun pulse; second rx triggers an overrun pulse and rx_data = second byte.
- Abort: SS_n rises after 4 bits -> no rx_valid, rx_data unchanged, MISO_OE=0 within 3 CLK; the next frame starts from the MSB.
- Reset mid-transfer: PRESETn low after 5 bits -> all outputs at reset values immediately; next full frame transfers correctly.
- SPE=0 mid-frame -> MISO_OE=0 next CLK, no rx_valid; rx_ack coincident with completion -> rx_valid stays 1, no overrun.
